// File: rtl/am_port_arbiter.sv
// Shares the single-port associative memory between encoder read, encoder write and external DMA
// ports. It issues one access per cycle and routes each read response back to its issuer.
module am_port_arbiter #(
   parameter int unsigned HV_LENGTH     = 2048,
   parameter int unsigned AM_ADDR_WIDTH = 13,
   parameter int unsigned MEM_RD_LAT    = 1,
   parameter int unsigned MAX_WAIT      = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,

   input  logic                     enc_rd_req_i,
   input  logic [AM_ADDR_WIDTH-1:0] enc_rd_addr_i,
   output logic                     enc_rd_gnt_o,
   output logic                     enc_rd_rvalid_o,
   output logic [HV_LENGTH-1:0]     enc_rd_rdata_o,

   input  logic                     enc_wr_req_i,
   input  logic [AM_ADDR_WIDTH-1:0] enc_wr_addr_i,
   input  logic [HV_LENGTH-1:0]     enc_wr_wdata_i,
   output logic                     enc_wr_gnt_o,

   input  logic                     ext_req_i,
   input  logic                     ext_we_i,
   input  logic [47:0]              ext_addr_i,
   input  logic [HV_LENGTH-1:0]     ext_wdata_i,
   output logic                     ext_gnt_o,
   output logic                     ext_rvalid_o,
   output logic [HV_LENGTH-1:0]     ext_rdata_o,
   output logic                     ext_err_o,

   output logic [AM_ADDR_WIDTH-1:0] mem_addr_o,
   output logic                     mem_ren_o,
   output logic                     mem_wen_o,
   output logic [HV_LENGTH-1:0]     mem_wdata_o,
   input  logic [HV_LENGTH-1:0]     mem_rdata_i
);

   localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
   localparam int unsigned Tail  = MEM_RD_LAT - 1;

   logic [WaitW-1:0]      wait_q, wait_d;
   logic [MEM_RD_LAT-1:0] vld_q, vld_d;
   logic [MEM_RD_LAT-1:0] dst_ext_q, dst_ext_d;
   logic [MEM_RD_LAT-1:0] oob_q, oob_d;
   logic                  wr_err_q, wr_err_d;

   logic forced;
   logic ext_oob;
   logic gnt_rd, gnt_wr, gnt_ext;
   logic issue_rd;

   assign ext_oob = |ext_addr_i[47:AM_ADDR_WIDTH];
   assign forced  = ext_req_i && (wait_q == WaitW'(MAX_WAIT));

   // Grants are masked during reset so every output sits at its reset value.
   always_comb begin
      gnt_rd  = 1'b0;
      gnt_wr  = 1'b0;
      gnt_ext = 1'b0;
      if (!rst_i) begin
         if (forced) begin
            gnt_ext = 1'b1;
         end else if (enc_rd_req_i) begin
            gnt_rd = 1'b1;
         end else if (enc_wr_req_i) begin
            gnt_wr = 1'b1;
         end else if (ext_req_i) begin
            gnt_ext = 1'b1;
         end
      end
   end

   assign enc_rd_gnt_o = gnt_rd;
   assign enc_wr_gnt_o = gnt_wr;
   assign ext_gnt_o    = gnt_ext;

   always_comb begin
      mem_addr_o  = '0;
      mem_ren_o   = 1'b0;
      mem_wen_o   = 1'b0;
      mem_wdata_o = '0;
      if (gnt_rd) begin
         mem_addr_o = enc_rd_addr_i;
         mem_ren_o  = 1'b1;
      end else if (gnt_wr) begin
         mem_addr_o  = enc_wr_addr_i;
         mem_wen_o   = 1'b1;
         mem_wdata_o = enc_wr_wdata_i;
      end else if (gnt_ext && !ext_oob) begin
         mem_addr_o = ext_addr_i[AM_ADDR_WIDTH-1:0];
         if (ext_we_i) begin
            mem_wen_o   = 1'b1;
            mem_wdata_o = ext_wdata_i;
         end else begin
            mem_ren_o = 1'b1;
         end
      end
   end

   // Out-of-range external reads still occupy a tag slot so they return zero data on time.
   assign issue_rd = gnt_rd || (gnt_ext && !ext_we_i);

   always_comb begin
      if (ext_req_i && !gnt_ext) begin
         wait_d = (wait_q == WaitW'(MAX_WAIT)) ? wait_q : wait_q + WaitW'(1);
      end else begin
         wait_d = '0;
      end

      vld_d        = '0;
      dst_ext_d    = '0;
      oob_d        = '0;
      vld_d[0]     = issue_rd;
      dst_ext_d[0] = gnt_ext;
      oob_d[0]     = gnt_ext && ext_oob;
      for (int i = 1; i < int'(MEM_RD_LAT); i++) begin
         vld_d[i]     = vld_q[i-1];
         dst_ext_d[i] = dst_ext_q[i-1];
         oob_d[i]     = oob_q[i-1];
      end

      wr_err_d = gnt_ext && ext_we_i && ext_oob;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wait_q    <= '0;
         vld_q     <= '0;
         dst_ext_q <= '0;
         oob_q     <= '0;
         wr_err_q  <= 1'b0;
      end else begin
         wait_q    <= wait_d;
         vld_q     <= vld_d;
         dst_ext_q <= dst_ext_d;
         oob_q     <= oob_d;
         wr_err_q  <= wr_err_d;
      end
   end

   assign enc_rd_rvalid_o = vld_q[Tail] && !dst_ext_q[Tail];
   assign enc_rd_rdata_o  = enc_rd_rvalid_o ? mem_rdata_i : '0;
   assign ext_rvalid_o    = vld_q[Tail] && dst_ext_q[Tail];
   assign ext_rdata_o     = (ext_rvalid_o && !oob_q[Tail]) ? mem_rdata_i : '0;
   assign ext_err_o       = (ext_rvalid_o && oob_q[Tail]) || wr_err_q;

endmodule

// File: tb/tb_am_port_arbiter.sv
// Directed bench: instance A (read latency 1) covers arbitration, starvation and range checks;
// instance B (read latency 2) covers reset while a read is in flight.
module tb_am_port_arbiter;

   localparam int unsigned HV = 64;
   localparam int unsigned AW = 13;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance A signals
   logic          rst;
   logic          enc_rd_req, enc_wr_req, ext_req, ext_we;
   logic [AW-1:0] enc_rd_addr, enc_wr_addr;
   logic [HV-1:0] enc_wr_wdata, ext_wdata;
   logic [47:0]   ext_addr;
   logic          enc_rd_gnt, enc_rd_rvalid, enc_wr_gnt, ext_gnt, ext_rvalid, ext_err;
   logic [HV-1:0] enc_rd_rdata, ext_rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_ren, mem_wen;
   logic [HV-1:0] mem_wdata, mem_rdata;

   // Instance B signals
   logic          b_rst;
   logic          b_enc_wr_req, b_ext_req;
   logic [AW-1:0] b_enc_wr_addr;
   logic [HV-1:0] b_enc_wr_wdata;
   logic [47:0]   b_ext_addr;
   logic          b_enc_rd_gnt, b_enc_rd_rvalid, b_enc_wr_gnt, b_ext_gnt, b_ext_rvalid, b_ext_err;
   logic [HV-1:0] b_enc_rd_rdata, b_ext_rdata;
   logic [AW-1:0] b_mem_addr;
   logic          b_mem_ren, b_mem_wen;
   logic [HV-1:0] b_mem_wdata, b_mem_rdata;

   am_port_arbiter #(
      .HV_LENGTH(HV), .AM_ADDR_WIDTH(AW), .MEM_RD_LAT(1), .MAX_WAIT(8)
   ) u_dut (
      .clk_i(clk), .rst_i(rst),
      .enc_rd_req_i(enc_rd_req), .enc_rd_addr_i(enc_rd_addr), .enc_rd_gnt_o(enc_rd_gnt),
      .enc_rd_rvalid_o(enc_rd_rvalid), .enc_rd_rdata_o(enc_rd_rdata),
      .enc_wr_req_i(enc_wr_req), .enc_wr_addr_i(enc_wr_addr), .enc_wr_wdata_i(enc_wr_wdata),
      .enc_wr_gnt_o(enc_wr_gnt),
      .ext_req_i(ext_req), .ext_we_i(ext_we), .ext_addr_i(ext_addr), .ext_wdata_i(ext_wdata),
      .ext_gnt_o(ext_gnt), .ext_rvalid_o(ext_rvalid), .ext_rdata_o(ext_rdata),
      .ext_err_o(ext_err),
      .mem_addr_o(mem_addr), .mem_ren_o(mem_ren), .mem_wen_o(mem_wen),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   am_port_arbiter #(
      .HV_LENGTH(HV), .AM_ADDR_WIDTH(AW), .MEM_RD_LAT(2), .MAX_WAIT(8)
   ) u_dut_b (
      .clk_i(clk), .rst_i(b_rst),
      .enc_rd_req_i(1'b0), .enc_rd_addr_i('0), .enc_rd_gnt_o(b_enc_rd_gnt),
      .enc_rd_rvalid_o(b_enc_rd_rvalid), .enc_rd_rdata_o(b_enc_rd_rdata),
      .enc_wr_req_i(b_enc_wr_req), .enc_wr_addr_i(b_enc_wr_addr),
      .enc_wr_wdata_i(b_enc_wr_wdata), .enc_wr_gnt_o(b_enc_wr_gnt),
      .ext_req_i(b_ext_req), .ext_we_i(1'b0), .ext_addr_i(b_ext_addr), .ext_wdata_i('0),
      .ext_gnt_o(b_ext_gnt), .ext_rvalid_o(b_ext_rvalid), .ext_rdata_o(b_ext_rdata),
      .ext_err_o(b_ext_err),
      .mem_addr_o(b_mem_addr), .mem_ren_o(b_mem_ren), .mem_wen_o(b_mem_wen),
      .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata)
   );

   // Memory models: A has one read stage, B has two.
   logic [HV-1:0] mem_a [0:(1<<AW)-1];
   logic [HV-1:0] mem_b [0:(1<<AW)-1];
   logic [HV-1:0] a_r1, b_r1, b_r2;

   always @(posedge clk) begin
      if (mem_ren) a_r1 <= mem_a[mem_addr];
      if (mem_wen) mem_a[mem_addr] <= mem_wdata;
      if (b_mem_ren) b_r1 <= mem_b[b_mem_addr];
      b_r2 <= b_r1;
      if (b_mem_wen) mem_b[b_mem_addr] <= b_mem_wdata;
   end
   assign mem_rdata   = a_r1;
   assign b_mem_rdata = b_r2;

   task automatic chk(input string tag, input logic [HV-1:0] obs, input logic [HV-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   localparam logic [HV-1:0] PatA5 = 64'hA5A5_A5A5_A5A5_A5A5;
   localparam logic [HV-1:0] DatD1 = 64'hD1D1_0000_0000_00D1;
   localparam logic [HV-1:0] DatE1 = 64'hE1E1_0000_0000_00E1;

   initial begin
      rst = 1'b1; b_rst = 1'b1;
      enc_rd_req = 0; enc_wr_req = 0; ext_req = 0; ext_we = 0;
      enc_rd_addr = '0; enc_wr_addr = '0; enc_wr_wdata = '0; ext_wdata = '0; ext_addr = '0;
      b_enc_wr_req = 0; b_ext_req = 0; b_enc_wr_addr = '0; b_enc_wr_wdata = '0; b_ext_addr = '0;

      // Reset: request held but nothing is granted or issued.
      @(negedge clk); enc_rd_req = 1; enc_rd_addr = 13'h010; #1;
      chk("rst_rd_gnt", enc_rd_gnt, 0);
      chk("rst_mem_ren", mem_ren, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_rd_rvalid", enc_rd_rvalid, 0);
      chk("rst_ext_err", ext_err, 0);
      chk("rst_wait", u_dut.wait_q, 0);

      // Preload through the write ports; first cycle after reset already grants.
      @(negedge clk); rst = 0; b_rst = 0; enc_rd_req = 0;
      enc_wr_req = 1; enc_wr_addr = 13'h010; enc_wr_wdata = PatA5;
      b_enc_wr_req = 1; b_enc_wr_addr = 13'h007; b_enc_wr_wdata = 64'h77; #1;
      chk("pre_wr_gnt", enc_wr_gnt, 1);
      chk("pre_wr_wen", mem_wen, 1);
      chk("pre_wr_wdata", mem_wdata, PatA5);
      @(negedge clk); enc_wr_addr = 13'h005; enc_wr_wdata = 64'h1; b_enc_wr_req = 0; #1;
      chk("pre_wr2_gnt", enc_wr_gnt, 1);
      @(negedge clk); enc_wr_req = 0; #1;
      chk("idle_wen", mem_wen, 0);

      // Single encoder read.
      @(negedge clk); enc_rd_req = 1; enc_rd_addr = 13'h010; #1;
      chk("t1_gnt", enc_rd_gnt, 1);
      chk("t1_ren", mem_ren, 1);
      chk("t1_addr", mem_addr, 13'h010);
      @(negedge clk); enc_rd_req = 0; #1;
      chk("t1_rvalid", enc_rd_rvalid, 1);
      chk("t1_rdata", enc_rd_rdata, PatA5);
      chk("t1_ext_rvalid", ext_rvalid, 0);
      chk("t1_ext_rdata", ext_rdata, 0);
      chk("t1_idle_addr", mem_addr, 0);
      @(negedge clk); #1;
      chk("t1_rvalid_once", enc_rd_rvalid, 0);

      // All three request together: enc_rd, enc_wr, ext in consecutive cycles.
      @(negedge clk);
      enc_rd_req = 1; enc_rd_addr = 13'h020;
      enc_wr_req = 1; enc_wr_addr = 13'h030; enc_wr_wdata = DatD1;
      ext_req = 1; ext_we = 1; ext_addr = 48'h040; ext_wdata = DatE1; #1;
      chk("t2_c1_rd", enc_rd_gnt, 1);
      chk("t2_c1_wr", enc_wr_gnt, 0);
      chk("t2_c1_ext", ext_gnt, 0);
      chk("t2_c1_en", {mem_ren, mem_wen}, 2'b10);
      @(negedge clk); enc_rd_req = 0; #1;
      chk("t2_c2_wr", enc_wr_gnt, 1);
      chk("t2_c2_ext", ext_gnt, 0);
      chk("t2_c2_en", {mem_ren, mem_wen}, 2'b01);
      chk("t2_c2_wdata", mem_wdata, DatD1);
      chk("t2_c2_rvalid", enc_rd_rvalid, 1);
      chk("t2_c2_wait", u_dut.wait_q, 1);
      @(negedge clk); enc_wr_req = 0; #1;
      chk("t2_c3_ext", ext_gnt, 1);
      chk("t2_c3_en", {mem_ren, mem_wen}, 2'b01);
      chk("t2_c3_addr", mem_addr, 13'h040);
      chk("t2_c3_wdata", mem_wdata, DatE1);
      @(negedge clk); ext_req = 0; ext_we = 0; #1;
      chk("t2_wait_clr", u_dut.wait_q, 0);
      chk("t2_no_err", ext_err, 0);
      chk("t2_no_rvalid", ext_rvalid, 0);

      // Starvation: continuous encoder reads plus an external read of 0x030.
      @(negedge clk);
      enc_rd_req = 1; enc_rd_addr = 13'h010; ext_req = 1; ext_we = 0; ext_addr = 48'h030;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("t3_deny%0d", i), ext_gnt, 0);
         chk($sformatf("t3_rd%0d", i), enc_rd_gnt, 1);
         chk($sformatf("t3_wait%0d", i), u_dut.wait_q, 64'(i));
         @(negedge clk);
      end
      #1;
      chk("t3_forced_gnt", ext_gnt, 1);
      chk("t3_forced_rd", enc_rd_gnt, 0);
      chk("t3_forced_addr", mem_addr, 13'h030);
      chk("t3_forced_ren", mem_ren, 1);
      @(negedge clk); ext_req = 0; #1;
      chk("t3_resume", enc_rd_gnt, 1);
      chk("t3_wait0", u_dut.wait_q, 0);
      chk("t3_ext_rvalid", ext_rvalid, 1);
      chk("t3_ext_rdata", ext_rdata, DatD1);
      chk("t3_enc_quiet", enc_rd_rvalid, 0);
      @(negedge clk); enc_rd_req = 0; #1;
      chk("t3_enc_rvalid", enc_rd_rvalid, 1);
      chk("t3_enc_rdata", enc_rd_rdata, PatA5);

      // Out-of-range external read, then write.
      @(negedge clk); ext_req = 1; ext_we = 0; ext_addr = 48'h2000; #1;
      chk("t4_gnt", ext_gnt, 1);
      chk("t4_en", {mem_ren, mem_wen}, 2'b00);
      chk("t4_addr", mem_addr, 0);
      @(negedge clk); ext_we = 1; ext_addr = 48'h2005; ext_wdata = DatE1; #1;
      chk("t4_rvalid", ext_rvalid, 1);
      chk("t4_rdata", ext_rdata, 0);
      chk("t4_err_rd", ext_err, 1);
      chk("t4_wgnt", ext_gnt, 1);
      chk("t4_wen", mem_wen, 0);
      @(negedge clk); ext_req = 0; ext_we = 0; #1;
      chk("t4_err_wr", ext_err, 1);
      chk("t4_wr_no_rvalid", ext_rvalid, 0);
      @(negedge clk); #1;
      chk("t4_err_pulse", ext_err, 0);

      // Same-cycle read and write to one address: old data first.
      @(negedge clk);
      enc_rd_req = 1; enc_rd_addr = 13'h005;
      enc_wr_req = 1; enc_wr_addr = 13'h005; enc_wr_wdata = 64'h2; #1;
      chk("t5_rd_gnt", enc_rd_gnt, 1);
      chk("t5_wr_wait", enc_wr_gnt, 0);
      @(negedge clk); enc_rd_req = 0; #1;
      chk("t5_wr_gnt", enc_wr_gnt, 1);
      chk("t5_old", enc_rd_rdata, 64'h1);
      @(negedge clk); enc_wr_req = 0; enc_rd_req = 1; #1;
      chk("t5_rd2_gnt", enc_rd_gnt, 1);
      @(negedge clk); enc_rd_req = 0; #1;
      chk("t5_new", enc_rd_rdata, 64'h2);

      // Latency-2 instance: reset while a read is in flight.
      @(negedge clk); b_ext_req = 1; b_ext_addr = 48'h007; #1;
      chk("t6_gnt", b_ext_gnt, 1);
      chk("t6_ren", b_mem_ren, 1);
      @(negedge clk); b_rst = 1; #1;
      chk("t6_rst_gnt", b_ext_gnt, 0);
      chk("t6_rst_ren", b_mem_ren, 0);
      chk("t6_rst_addr", b_mem_addr, 0);
      chk("t6_rst_rvalid", b_ext_rvalid, 0);
      chk("t6_rst_err", b_ext_err, 0);
      @(negedge clk); #1;
      chk("t6_dropped", b_ext_rvalid, 0);
      chk("t6_dropped_data", b_ext_rdata, 0);
      @(negedge clk); b_rst = 0; b_ext_req = 0; #1;
      chk("t6_post_rvalid", b_ext_rvalid, 0);
      @(negedge clk); b_ext_req = 1; #1;
      chk("t6_new_gnt", b_ext_gnt, 1);
      @(negedge clk); b_ext_req = 0; #1;
      chk("t6_lat_not_yet", b_ext_rvalid, 0);
      @(negedge clk); #1;
      chk("t6_new_rvalid", b_ext_rvalid, 1);
      chk("t6_new_rdata", b_ext_rdata, 64'h77);
      @(negedge clk); #1;
      chk("t6_rvalid_once", b_ext_rvalid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/am_port_arbiter.md
# am_port_arbiter

Arbiter that shares the single-port associative memory (AM) between three requesters: the encoder read port, the encoder write port and the external DMA port. It sits between `top_system` and `am_memory`. It grants one access per cycle and tracks outstanding reads so each read response returns to its issuer. A starvation counter bounds the wait of the external port.

## Interface
Parameters:
- HV_LENGTH, 2048, hypervector / memory word width in bits
- AM_ADDR_WIDTH, 13, AM address width
- MEM_RD_LAT, 1, AM read latency in cycles (>=1)
- MAX_WAIT, 8, cycles the external port may be denied before it is forced to win (>=1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- enc_rd_req_i  in  1  encoder read request
- enc_rd_addr_i  in  AM_ADDR_WIDTH  encoder read address
- enc_rd_gnt_o  out  1  encoder read granted this cycle
- enc_rd_rvalid_o  out  1  encoder read data valid
- enc_rd_rdata_o  out  HV_LENGTH  encoder read data
- enc_wr_req_i  in  1  encoder write request
- enc_wr_addr_i  in  AM_ADDR_WIDTH  encoder write address
- enc_wr_wdata_i  in  HV_LENGTH  encoder write data
- enc_wr_gnt_o  out  1  encoder write granted this cycle
- ext_req_i  in  1  external (DMA) request
- ext_we_i  in  1  external request is a write (1) or a read (0)
- ext_addr_i  in  48  external address
- ext_wdata_i  in  HV_LENGTH  external write data
- ext_gnt_o  out  1  external request granted this cycle
- ext_rvalid_o  out  1  external read data valid
- ext_rdata_o  out  HV_LENGTH  external read data
- ext_err_o  out  1  one-cycle pulse: out-of-range external access completed
- mem_addr_o  out  AM_ADDR_WIDTH  AM address
- mem_ren_o  out  1  AM read enable
- mem_wen_o  out  1  AM write enable
- mem_wdata_o  out  HV_LENGTH  AM write data
- mem_rdata_i  in  HV_LENGTH  AM read data, MEM_RD_LAT cycles after mem_ren_o

## Operation
- The request/grant handshake follows req/gnt. A request is held until it is granted. Grants are combinational in the request cycle, at most one per cycle.
- Priority, normal mode: enc_rd > enc_wr > ext.
- Forced mode: when wait_q == MAX_WAIT and ext_req_i is high, ext wins over both encoder ports.
- wait_q counter:
  - Width $clog2(MAX_WAIT+1), saturating.
  - Increments on cycles with ext_req_i && !ext_gnt_o.
  - Clears on ext_gnt_o or when ext_req_i is low.
- Memory command is driven combinationally from the winner in the grant cycle:
  - Read: mem_ren_o=1.
  - Write: mem_wen_o=1, mem_wdata_o = winner data.
  - Never both enables at once.
  - When idle: mem_ren_o=mem_wen_o=0; mem_addr_o and mem_wdata_o are 0.
- External address range check:
  - If ext_addr_i[47:AM_ADDR_WIDTH] != 0, the access is granted but not issued (mem_ren_o=mem_wen_o=0).
  - A write is dropped.
  - A read returns ext_rvalid_o with ext_rdata_o = 0 after MEM_RD_LAT cycles.
  - ext_err_o pulses in the same cycle as that response (for a read) or in the cycle after the grant (for a write).
- Read return tracking:
  - A tag shift register of depth MEM_RD_LAT records {valid, dest(enc/ext), oob} per cycle.
  - At the tail, rvalid and rdata route to the tagged destination. The non-selected rdata output is 0.
- Same cycle, enc_rd and enc_wr to the same address: the read wins and returns the old data. The write is granted in a later cycle.
- Writes have no response.

## Timing
- Reset values: all gnt, rvalid and err outputs 0; all rdata outputs 0; all mem_* outputs 0; wait_q=0; tag pipeline cleared.
- Grant latency: 0 cycles when uncontested.
- Read latency: grant cycle T -> rvalid at T+MEM_RD_LAT, for exactly 1 cycle.
- Throughput: 1 access per cycle, back-to-back reads pipelined with no bubbles.
- Worst-case external wait: MAX_WAIT denied cycles, then a grant in the next cycle.
- Reset mid-operation:
  - Asserting rst_i drops all in-flight reads; no rvalid is emitted for them.
  - Outputs take their reset values asynchronously.
  - The first grant is possible in the first cycle after rst_i deasserts.
- Inputs are sampled only in the grant cycle. Requesters may change addr/data after gnt.

## Test plan
- Single encoder read of addr 0x010 (mem holds 0xA5 pattern) -> enc_rd_gnt_o in cycle T; enc_rd_rvalid_o with that data at T+1 (MEM_RD_LAT=1); ext_rvalid_o stays 0.
- enc_rd, enc_wr and ext all requesting in the same cycle -> grant order enc_rd, then enc_wr, then ext in three consecutive cycles; exactly one mem enable per cycle.
- Encoder read requested continuously plus ext_req_i, MAX_WAIT=8 -> ext denied 8 cycles, granted in the 9th; wait_q returns to 0; encoder resumes the next cycle.
- Ext read with ext_addr_i=0x2000 (bit 13 set) -> granted, no mem_ren_o; at T+1 ext_rvalid_o=1, ext_rdata_o=0, ext_err_o=1.
- Enc_rd and enc_wr same cycle, both to addr 0x005, old data 0x1, new data 0x2 -> read returns 0x1; write is granted the next cycle; a later read returns 0x2.
- Ext read granted at T with MEM_RD_LAT=2, rst_i asserted at T+1 -> no ext_rvalid_o ever; all outputs 0 during reset; a new read after reset completes normally.
